// File: rtl/vita49_pack_if.sv
// AXI4-Stream bundle used on both sides of the VITA49 packer.
interface vita49_pack_if;
    logic [31:0] TDATA;
    logic        TVALID;
    logic        TLAST;
    logic        TREADY;

    modport master (output TDATA, output TVALID, output TLAST, input TREADY);
    modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);
endinterface

// File: rtl/vita49_pack.sv
// VITA49 packer: wraps a raw sample stream into IF-data packets carrying a
// stream ID, integer-seconds and fractional timestamps, N payload words each.
// A passthrough mode bypasses the framer entirely.
module vita49_pack #(
    parameter logic [3:0] PKT_TYPE = 4'h1
) (
    input  logic                AXIS_ACLK,
    input  logic                AXIS_ARESETN,
    vita49_pack_if.slave        s_axis,
    vita49_pack_if.master       m_axis,
    input  logic [31:0]         ctrl,
    input  logic [31:0]         streamID,
    input  logic [15:0]         pkt_payload_words,
    input  logic [31:0]         words_to_pack,
    input  logic [31:0]         timestamp_sec,
    input  logic [63:0]         timestamp_fsec,
    output logic [31:0]         status
);

    typedef enum logic [3:0] {
        IDLE, HDR, SID, TSI, TSF0, TSF1, PAYLOAD, ERROR, DONE
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  rst_sync;
    logic        rst_n;
    logic [15:0] n_lat;
    logic [15:0] payload_cnt;
    logic [31:0] word_cnt;
    logic [3:0]  pkt_cnt;
    logic        done;
    logic        cfg_err;
    logic [31:0] ts_sec;
    logic [63:0] ts_fsec;

    logic [31:0] m_tdata;
    logic        m_tvalid, m_tlast, s_tready;
    logic        m_fire;

    wire start    = ctrl[0];
    wire rcmd     = ctrl[1];
    wire pt       = ctrl[2];
    wire cfg_bad  = (pkt_payload_words == 16'd0) || (pkt_payload_words > 16'hFFFA);
    wire last_pl  = (payload_cnt == n_lat - 16'd1);
    wire stop_run = (words_to_pack != 32'd0) &&
                    (({1'b0, word_cnt} + 33'd1) >= {1'b0, words_to_pack});
    wire busy     = (state == HDR) || (state == SID) || (state == TSI) ||
                    (state == TSF0) || (state == TSF1) || (state == PAYLOAD);

    logic [15:0] hdr_len;
    logic [31:0] hdr_word;
    assign hdr_len  = n_lat + 16'd5;
    assign hdr_word = {PKT_TYPE, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, pkt_cnt, hdr_len};

    logic unused_ctrl;
    assign unused_ctrl = ^ctrl[31:3];

    // Reset asserts asynchronously, releases two clocks later on AXIS_ACLK.
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) rst_sync <= 2'b00;
        else               rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // Output datapath: word mux per state; reset_cmd idles the bus, passthrough wires S to M.
    always_comb begin
        m_tdata  = 32'h0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        s_tready = 1'b0;
        case (state)
            HDR:     begin m_tdata = hdr_word;              m_tvalid = s_axis.TVALID; end
            SID:     begin m_tdata = streamID;              m_tvalid = 1'b1; end
            TSI:     begin m_tdata = ts_sec;                m_tvalid = 1'b1; end
            TSF0:    begin m_tdata = ts_fsec[63:32];        m_tvalid = 1'b1; end
            TSF1:    begin m_tdata = ts_fsec[31:0];         m_tvalid = 1'b1; end
            PAYLOAD: begin
                m_tdata  = s_axis.TDATA;
                m_tvalid = s_axis.TVALID;
                m_tlast  = last_pl;
                s_tready = m_axis.TREADY;
            end
            default: ;
        endcase
        // An abandoned packet must not move a word in the cycle it is dropped.
        if (rcmd) begin
            m_tvalid = 1'b0;
            m_tlast  = 1'b0;
            s_tready = 1'b0;
        end
        if (pt) begin
            m_tdata  = s_axis.TDATA;
            m_tvalid = s_axis.TVALID;
            m_tlast  = s_axis.TLAST;
            s_tready = m_axis.TREADY;
        end
    end

    assign m_axis.TDATA  = m_tdata;
    assign m_axis.TVALID = m_tvalid;
    assign m_axis.TLAST  = m_tlast;
    assign s_axis.TREADY = s_tready;

    // Framer only advances on its own transfers, never on passthrough traffic.
    assign m_fire = m_tvalid & m_axis.TREADY & ~pt;

    // Next-state: one header word per transfer, then N payload words.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = cfg_bad ? ERROR : HDR;
            HDR:     if (m_fire) state_nxt = SID;
            SID:     if (m_fire) state_nxt = TSI;
            TSI:     if (m_fire) state_nxt = TSF0;
            TSF0:    if (m_fire) state_nxt = TSF1;
            TSF1:    if (m_fire) state_nxt = PAYLOAD;
            PAYLOAD: if (m_fire && last_pl) state_nxt = stop_run ? DONE : HDR;
            ERROR:   state_nxt = ERROR;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (pt)   state_nxt = state;
        if (rcmd) state_nxt = IDLE;
    end

    // State register.
    always_ff @(posedge AXIS_ACLK or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Counters, flags and timestamp capture.
    always_ff @(posedge AXIS_ACLK or negedge rst_n) begin
        if (!rst_n) begin
            n_lat       <= 16'd0;
            payload_cnt <= 16'd0;
            word_cnt    <= 32'd0;
            pkt_cnt     <= 4'd0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
            ts_sec      <= 32'd0;
            ts_fsec     <= 64'd0;
        end else if (rcmd) begin
            payload_cnt <= 16'd0;
            word_cnt    <= 32'd0;
            pkt_cnt     <= 4'd0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
        end else if (!pt) begin
            case (state)
                IDLE: begin
                    payload_cnt <= 16'd0;
                    word_cnt    <= 32'd0;
                    pkt_cnt     <= 4'd0;
                    done        <= 1'b0;
                    cfg_err     <= 1'b0;
                    if (start) begin
                        n_lat   <= pkt_payload_words;
                        cfg_err <= cfg_bad;
                    end
                end
                HDR: if (m_fire) begin
                    ts_sec  <= timestamp_sec;
                    ts_fsec <= timestamp_fsec;
                end
                PAYLOAD: if (m_fire) begin
                    word_cnt <= word_cnt + 32'd1;
                    if (last_pl) begin
                        payload_cnt <= 16'd0;
                        pkt_cnt     <= pkt_cnt + 4'd1;
                        if (stop_run) done <= 1'b1;
                    end else begin
                        payload_cnt <= payload_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign status = {16'h0, pkt_cnt, 8'h0, busy, cfg_err, 1'b0, done};

endmodule
